// File: rtl/out_port_unit_pkg.sv
// out_port_unit_pkg: shared CPU constants for the output port unit.
package out_port_unit_pkg;
  localparam int CPU_WORD_W = 32;
  localparam int CPU_PORT_DEPTH = 4;
endpackage

// File: rtl/out_port_unit_port_fifo.sv
// port_fifo: power-of-two circular FIFO with occupancy count and sync active-low clear.
module port_fifo
  import out_port_unit_pkg::*;
#(
  parameter int DEPTH  = CPU_PORT_DEPTH,
  parameter int WORD_W = CPU_WORD_W
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic push_ok, pop_ok;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign rdata = mem_q[rd_q];
  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_q] = wdata;
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge clock) begin
    if (!clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // storage is deliberately left uncleared; only pointers define validity
  always_ff @(posedge clock) mem_q <= mem_d;
endmodule

// File: rtl/out_port_unit.sv
// out_port_unit: CPU output port capturing bus words into a FIFO drained by a valid/ready device.
module out_port_unit
  import out_port_unit_pkg::*;
#(
  parameter int DEPTH  = CPU_PORT_DEPTH,
  parameter int WORD_W = CPU_WORD_W
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     OutPort_In,
  input  logic [WORD_W-1:0]        BusMuxOut,
  output logic [WORD_W-1:0]        OutPortData,
  output logic [WORD_W-1:0]        dev_data,
  output logic                     dev_valid,
  input  logic                     dev_ready,
  output logic                     port_full,
  output logic                     port_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic overflow_q, overflow_d;
  logic push, pop;
  port_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (BusMuxOut),
    .rdata (dev_data),
    .full  (port_full),
    .empty (port_empty),
    .count (count)
  );
  assign dev_valid   = !port_empty;
  assign OutPortData = out_data_q;
  assign overflow    = overflow_q;
  always_comb begin
    push       = OutPort_In && !port_full;
    pop        = dev_valid && dev_ready;
    out_data_d = push ? BusMuxOut : out_data_q;
    overflow_d = overflow_q || (OutPort_In && port_full);
  end
  always_ff @(posedge clock) begin
    if (!clear) begin
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_out_port_unit.sv
// tb_out_port_unit: directed self-checking bench for out_port_unit.
module tb_out_port_unit;
  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        OutPort_In = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic [31:0] OutPortData, dev_data;
  logic        dev_valid, port_full, port_empty, overflow;
  logic        dev_ready = 1'b0;
  logic [2:0]  count;
  int checks = 0;
  int errors = 0;

  out_port_unit dut (
    .clock       (clock),
    .clear       (clear),
    .OutPort_In  (OutPort_In),
    .BusMuxOut   (BusMuxOut),
    .OutPortData (OutPortData),
    .dev_data    (dev_data),
    .dev_valid   (dev_valid),
    .dev_ready   (dev_ready),
    .port_full   (port_full),
    .port_empty  (port_empty),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (port_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", port_empty); end
    checks++; if (port_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", port_full); end
    checks++; if (dev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dev_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (OutPortData !== 32'h0) begin errors++; $display("FAIL reset_outdata got=%h exp=0", OutPortData); end
  endtask

  task automatic test_single_word();
    OutPort_In = 1'b1;
    BusMuxOut = 32'hABCDDCBA;
    dev_ready = 1'b0;
    tick();
    OutPort_In = 1'b0;
    checks++; if (OutPortData !== 32'hABCDDCBA) begin errors++; $display("FAIL single_outdata got=%h exp=abcddcba", OutPortData); end
    checks++; if (dev_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", dev_valid); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
    checks++; if (dev_data !== 32'hABCDDCBA) begin errors++; $display("FAIL single_devdata got=%h exp=abcddcba", dev_data); end
    dev_ready = 1'b1;
    tick();
    dev_ready = 1'b0;
    checks++; if (port_empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", port_empty); end
    checks++; if (dev_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after got=%b exp=0", dev_valid); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 4; i++) begin
      OutPort_In = 1'b1;
      BusMuxOut = 32'(i);
      tick();
    end
    checks++; if (port_full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", port_full); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_early got=%b exp=0", overflow); end
    BusMuxOut = 32'd5;
    tick();
    OutPort_In = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (OutPortData !== 32'd4) begin errors++; $display("FAIL ovf_outdata got=%0d exp=4", OutPortData); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", count); end
    // full push with concurrent pop must still be refused
    OutPort_In = 1'b1;
    BusMuxOut = 32'd6;
    dev_ready = 1'b1;
    checks++; if (dev_data !== 32'd1) begin errors++; $display("FAIL drain_0 got=%0d exp=1", dev_data); end
    tick();
    OutPort_In = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL nobypass_count got=%0d exp=3", count); end
    checks++; if (OutPortData !== 32'd4) begin errors++; $display("FAIL nobypass_outdata got=%0d exp=4", OutPortData); end
    for (int i = 2; i <= 4; i++) begin
      checks++; if (dev_data !== 32'(i) || dev_valid !== 1'b1) begin errors++; $display("FAIL drain_%0d got=%0d/%b exp=%0d/1", i, dev_data, dev_valid, i); end
      tick();
    end
    dev_ready = 1'b0;
    checks++; if (port_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", port_empty); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_stall();
    OutPort_In = 1'b1;
    BusMuxOut = 32'd7;
    tick();
    BusMuxOut = 32'd8;
    tick();
    OutPort_In = 1'b0;
    dev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dev_data !== 32'd7) begin errors++; $display("FAIL stall_data_%0d got=%0d exp=7", i, dev_data); end
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL stall_count_%0d got=%0d exp=2", i, count); end
    end
  endtask

  task automatic test_back_to_back();
    OutPort_In = 1'b1;
    BusMuxOut = 32'd9;
    dev_ready = 1'b1;
    tick();
    OutPort_In = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", count); end
    checks++; if (dev_data !== 32'd8) begin errors++; $display("FAIL b2b_head got=%0d exp=8", dev_data); end
    tick();
    checks++; if (dev_data !== 32'd9) begin errors++; $display("FAIL b2b_tail got=%0d exp=9", dev_data); end
    tick();
    dev_ready = 1'b0;
    checks++; if (port_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", port_empty); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_q[$];
    logic [15:0] pat;
    int n;
    int rcv;
    pat = 16'b1011_0010_0100_0110;
    n = 0;
    rcv = 0;
    for (int c = 0; c < 200 && rcv < 10; c++) begin
      OutPort_In = (n < 10) && !port_full;
      BusMuxOut = 32'h100 + 32'(n);
      dev_ready = pat[c % 16];
      if (dev_valid && dev_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stream_spurious got=%h exp=none", dev_data); end
        else begin
          if (dev_data !== exp_q[0]) begin errors++; $display("FAIL stream_word_%0d got=%h exp=%h", rcv, dev_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        rcv++;
      end
      if (OutPort_In) begin exp_q.push_back(BusMuxOut); n++; end
      tick();
    end
    OutPort_In = 1'b0;
    dev_ready = 1'b0;
    checks++; if (rcv != 10) begin errors++; $display("FAIL stream_received got=%0d exp=10", rcv); end
    checks++; if (port_empty !== 1'b1) begin errors++; $display("FAIL stream_empty got=%b exp=1", port_empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      OutPort_In = 1'b1;
      BusMuxOut = 32'h50 + 32'(i);
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    clear = 1'b0;
    dev_ready = 1'b1;
    BusMuxOut = 32'h77;
    tick();
    clear = 1'b1;
    OutPort_In = 1'b0;
    dev_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (dev_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", dev_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
    checks++; if (OutPortData !== 32'h0) begin errors++; $display("FAIL mid_outdata got=%h exp=0", OutPortData); end
  endtask

  initial begin
    tick();
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_stall();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
